// File: rtl/w_buffer_loader_if.sv
// w_buffer_loader_if: controller handshake, source BRAM read port and weight-RAM write port of the loader
interface w_buffer_loader_if #(
   parameter int ADDR_WIDTH      = 8,
   parameter int ARRAY_M         = 8,
   parameter int WGT_WIDTH       = 8,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int BRAM_ADDR_WIDTH = 12
);
   localparam int CW = $clog2(ARRAY_M) + 1;
   logic                       start;
   logic [BRAM_ADDR_WIDTH-1:0] src_base;
   logic [ADDR_WIDTH-1:0]      dst_base;
   logic [ADDR_WIDTH:0]        num_rows;
   logic [CW-1:0]              num_cols;
   logic                       bram_en;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr;
   logic [BRAM_DATA_WIDTH-1:0] bram_rdata;
   logic [ADDR_WIDTH-1:0]      bram_to_ram_w_addr;
   logic [ARRAY_M-1:0]         bram_to_ram_w_en;
   logic [WGT_WIDTH-1:0]       bram_to_ram_w_data;
   logic                       busy;
   logic                       done;
   modport master (
      output start, src_base, dst_base, num_rows, num_cols, bram_rdata,
      input  bram_en, bram_addr, bram_to_ram_w_addr, bram_to_ram_w_en, bram_to_ram_w_data, busy, done
   );
   modport slave (
      input  start, src_base, dst_base, num_rows, num_cols, bram_rdata,
      output bram_en, bram_addr, bram_to_ram_w_addr, bram_to_ram_w_en, bram_to_ram_w_data, busy, done
   );
endinterface

// File: rtl/w_buffer_loader.sv
// w_buffer_loader: unpacks a column-major weight tile from wide BRAM words into the per-column weight RAMs
module w_buffer_loader #(
   parameter int ADDR_WIDTH      = 8,
   parameter int ARRAY_M         = 8,
   parameter int WGT_WIDTH       = 8,
   parameter int BRAM_DATA_WIDTH = 32,
   parameter int BRAM_ADDR_WIDTH = 12,
   parameter int BPW             = BRAM_DATA_WIDTH / WGT_WIDTH
) (
   input logic clk,
   input logic reset,
   w_buffer_loader_if.slave bus
);
   localparam int CW = $clog2(ARRAY_M) + 1;
   localparam int LW = BPW > 1 ? $clog2(BPW) : 1;

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, EMIT, DONE} state_t;

   state_t                     state_q, state_d;
   logic [BRAM_ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [ADDR_WIDTH-1:0]      dst_q, dst_d;
   logic [ADDR_WIDTH:0]        nrows_q, nrows_d;
   logic [CW-1:0]              ncols_q, ncols_d;
   logic [ADDR_WIDTH-1:0]      row_q, row_d;
   logic [CW-1:0]              col_q, col_d;
   logic [LW-1:0]              lane_q, lane_d;
   logic [BRAM_DATA_WIDTH-1:0] word_q, word_d;
   logic                       skip_q, skip_d;
   logic                       bram_en_q, bram_en_d;
   logic [BRAM_ADDR_WIDTH-1:0] bram_addr_q, bram_addr_d;
   logic [ARRAY_M-1:0]         w_en_q, w_en_d;
   logic [ADDR_WIDTH-1:0]      w_addr_q, w_addr_d;
   logic [WGT_WIDTH-1:0]       w_data_q, w_data_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;

   logic                  row_last, col_last, lane_last, empty;
   logic [ADDR_WIDTH-1:0] row_nx;
   logic [CW-1:0]         col_nx, ncols_clamp;
   logic [LW-1:0]         lane_nx;

   // row/col/lane always point at the weight being written (EMIT) or about to be written (FETCH/WAIT)
   assign row_last    = {1'b0, row_q} == nrows_q - 1'b1;
   assign col_last    = col_q == ncols_q - 1'b1;
   assign lane_last   = lane_q == LW'(BPW - 1);
   assign row_nx      = row_last ? '0 : row_q + 1'b1;
   assign col_nx      = row_last ? col_q + 1'b1 : col_q;
   assign lane_nx     = lane_q + 1'b1;
   assign ncols_clamp = bus.num_cols > CW'(ARRAY_M) ? CW'(ARRAY_M) : bus.num_cols;
   assign empty       = bus.num_rows == '0 || bus.num_cols == '0;

   // next state, counters and the registered copies of every output
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      dst_d       = dst_q;
      nrows_d     = nrows_q;
      ncols_d     = ncols_q;
      row_d       = row_q;
      col_d       = col_q;
      lane_d      = lane_q;
      word_d      = word_q;
      skip_d      = skip_q;
      bram_en_d   = 1'b0;
      bram_addr_d = bram_addr_q;
      w_en_d      = '0;
      w_addr_d    = w_addr_q;
      w_data_d    = w_data_q;
      done_d      = 1'b0;
      unique case (state_q)
         IDLE: if (bus.start) begin
            ptr_d       = bus.src_base;
            dst_d       = bus.dst_base;
            nrows_d     = bus.num_rows;
            ncols_d     = ncols_clamp;
            row_d       = '0;
            col_d       = '0;
            lane_d      = '0;
            skip_d      = empty;
            bram_en_d   = !empty;
            bram_addr_d = bus.src_base;
            state_d     = empty ? DONE : FETCH;
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            word_d   = bus.bram_rdata;
            w_en_d   = ARRAY_M'(1) << col_q;
            w_addr_d = dst_q + row_q;
            w_data_d = bus.bram_rdata[WGT_WIDTH-1:0];
            state_d  = EMIT;
         end
         EMIT: if (row_last && col_last) begin
            done_d  = 1'b1;
            state_d = DONE;
         end else begin
            row_d = row_nx;
            col_d = col_nx;
            if (lane_last) begin
               lane_d      = '0;
               ptr_d       = ptr_q + 1'b1;
               bram_en_d   = 1'b1;
               bram_addr_d = ptr_q + 1'b1;
               state_d     = FETCH;
            end else begin
               lane_d   = lane_nx;
               w_en_d   = ARRAY_M'(1) << col_nx;
               w_addr_d = dst_q + row_nx;
               w_data_d = word_q[lane_nx*WGT_WIDTH +: WGT_WIDTH];
            end
         end
         // an empty tile spends one settle cycle here before pulsing done
         DONE: begin
            skip_d  = 1'b0;
            done_d  = skip_q;
            state_d = skip_q ? DONE : IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d == FETCH || state_d == WAIT || state_d == EMIT;
   end

   // state and output registers; reset aborts any transfer immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         dst_q       <= '0;
         nrows_q     <= '0;
         ncols_q     <= '0;
         row_q       <= '0;
         col_q       <= '0;
         lane_q      <= '0;
         word_q      <= '0;
         skip_q      <= 1'b0;
         bram_en_q   <= 1'b0;
         bram_addr_q <= '0;
         w_en_q      <= '0;
         w_addr_q    <= '0;
         w_data_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         dst_q       <= dst_d;
         nrows_q     <= nrows_d;
         ncols_q     <= ncols_d;
         row_q       <= row_d;
         col_q       <= col_d;
         lane_q      <= lane_d;
         word_q      <= word_d;
         skip_q      <= skip_d;
         bram_en_q   <= bram_en_d;
         bram_addr_q <= bram_addr_d;
         w_en_q      <= w_en_d;
         w_addr_q    <= w_addr_d;
         w_data_q    <= w_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.bram_en            = bram_en_q;
   assign bus.bram_addr          = bram_addr_q;
   assign bus.bram_to_ram_w_en   = w_en_q;
   assign bus.bram_to_ram_w_addr = w_addr_q;
   assign bus.bram_to_ram_w_data = w_data_q;
   assign bus.busy               = busy_q;
   assign bus.done               = done_q;
endmodule

// File: tb/tb_w_buffer_loader.sv
// tb_w_buffer_loader: randomized tiles checked against an arithmetic model of the tile layout and timing
module tb_w_buffer_loader;
   localparam int AW = 8, M = 8, WW = 8, BDW = 32, BAW = 12, BPW = BDW / WW;

   typedef struct {int col; int addr; int data; int cyc;} wr_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   w_buffer_loader_if #(.ADDR_WIDTH(AW), .ARRAY_M(M), .WGT_WIDTH(WW), .BRAM_DATA_WIDTH(BDW), .BRAM_ADDR_WIDTH(BAW)) bus ();

   w_buffer_loader #(.ADDR_WIDTH(AW), .ARRAY_M(M), .WGT_WIDTH(WW), .BRAM_DATA_WIDTH(BDW), .BRAM_ADDR_WIDTH(BAW)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   logic [BDW-1:0] mem [0:(1<<BAW)-1];
   wr_t wq[$];
   int  rq[$];
   int  cyc = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, bad_oh = 0, last_t0 = 0;
   int  n_checks = 0, n_fail = 0;

   // BRAM with one-cycle read latency
   always @(posedge clk) if (bus.bram_en) bus.bram_rdata <= mem[bus.bram_addr];

   always @(posedge clk) cyc <= cyc + 1;

   // observe the DUT mid-cycle
   always @(negedge clk) begin
      if (bus.bram_to_ram_w_en != '0) begin
         if ($onehot(bus.bram_to_ram_w_en)) begin
            int c;
            c = 0;
            for (int j = 0; j < M; j++) if (bus.bram_to_ram_w_en[j]) c = j;
            wq.push_back('{c, int'(bus.bram_to_ram_w_addr), int'(bus.bram_to_ram_w_data), cyc});
         end else bad_oh++;
      end
      if (bus.bram_en) rq.push_back(int'(bus.bram_addr));
      if (bus.done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) bad_oh++;
   end

   task automatic run_tile(input string name, input int src, input int dst, input int rows, input int cols, input int s1);
      int ce, n, words, doff, t0, ew, ea, ed;
      logic [BDW-1:0] word;
      ce    = cols > M ? M : cols;
      n     = rows * ce;
      words = (n + BPW - 1) / BPW;
      doff  = n == 0 ? 2 : ((n - 1) / BPW) * (2 + BPW) + 3 + (n - 1) % BPW + 1;
      @(negedge clk);
      wq.delete();
      rq.delete();
      done_cnt = 0;
      busy_cnt = 0;
      bad_oh   = 0;
      bus.src_base = BAW'(src);
      bus.dst_base = AW'(dst);
      bus.num_rows = (AW+1)'(rows);
      bus.num_cols = 4'(cols);
      bus.start    = 1'b1;
      @(posedge clk);
      #1 t0 = cyc - 1;
      last_t0 = t0;
      for (int i = 0; i < doff + 8; i++) begin
         @(negedge clk);
         bus.start = s1 != 0 && (cyc - t0 == s1 || cyc - t0 == doff);
         if (bus.start) begin
            bus.src_base = BAW'($urandom);
            bus.dst_base = AW'($urandom);
            bus.num_rows = (AW+1)'($urandom_range(1, 9));
            bus.num_cols = 4'($urandom_range(1, 8));
         end
      end
      bus.start = 1'b0;
      n_checks++;
      if (wq.size() !== n) begin
         n_fail++;
         $display("FAIL %s write_count got %0d expected %0d", name, wq.size(), n);
      end
      for (int k = 0; k < n && k < wq.size(); k++) begin
         word = mem[(src + k / BPW) % (1 << BAW)];
         ew   = t0 + (k / BPW) * (2 + BPW) + 3 + k % BPW;
         ea   = (dst + k % rows) % (1 << AW);
         ed   = int'(word[WW*(k%BPW) +: WW]);
         n_checks++;
         if (wq[k].col !== k / rows || wq[k].addr !== ea || wq[k].data !== ed || wq[k].cyc !== ew) begin
            n_fail++;
            $display("FAIL %s write%0d got col%0d @%0h=%0h cyc%0d expected col%0d @%0h=%0h cyc%0d",
                     name, k, wq[k].col, wq[k].addr, wq[k].data, wq[k].cyc - t0, k / rows, ea, ed, ew - t0);
         end
      end
      n_checks++;
      if (rq.size() !== words) begin
         n_fail++;
         $display("FAIL %s read_count got %0d expected %0d", name, rq.size(), words);
      end
      for (int w = 0; w < words && w < rq.size(); w++) begin
         n_checks++;
         if (rq[w] !== (src + w) % (1 << BAW)) begin
            n_fail++;
            $display("FAIL %s read%0d addr got %0h expected %0h", name, w, rq[w], (src + w) % (1 << BAW));
         end
      end
      n_checks++;
      if (done_cnt !== 1 || done_cyc - t0 !== doff) begin
         n_fail++;
         $display("FAIL %s done got %0d pulses at cycle %0d expected 1 at cycle %0d", name, done_cnt, done_cyc - t0, doff);
      end
      n_checks++;
      if (busy_cnt !== (n == 0 ? 0 : doff - 1) || bad_oh !== 0) begin
         n_fail++;
         $display("FAIL %s busy got %0d cycles (bad strobes %0d) expected %0d", name, busy_cnt, bad_oh, n == 0 ? 0 : doff - 1);
      end
   endtask

   task automatic test_reset();
      #1;
      n_checks++;
      if ({bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done, bus.bram_addr, bus.bram_to_ram_w_addr, bus.bram_to_ram_w_data} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs got en=%b wen=%h busy=%b done=%b expected all 0", bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done);
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done} !== '0) begin
         n_fail++;
         $display("FAIL idle_outputs got en=%b wen=%h busy=%b done=%b expected all 0", bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done);
      end
   endtask

   task automatic test_basic();
      mem[12'h010] = 32'h44332211;
      mem[12'h011] = {16'($urandom), 16'h6655};
      run_tile("basic", 'h010, 'h20, 3, 2, 0);
      n_checks++;
      if (wq[3].col !== 1 || wq[3].addr !== 'h20 || wq[3].data !== 'h44 || wq[5].data !== 'h66 || wq[5].addr !== 'h22) begin
         n_fail++;
         $display("FAIL basic_values got w3=col%0d@%0h=%0h w5=@%0h=%0h expected col1@20=44 @22=66",
                  wq[3].col, wq[3].addr, wq[3].data, wq[5].addr, wq[5].data);
      end
   endtask

   task automatic test_full();
      int dst;
      dst = 'h40;
      for (int w = 0; w < 16; w++) mem['h100 + w] = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      run_tile("full", 'h100, dst, 8, 8, 0);
      for (int k = 56; k < 64; k++) begin
         n_checks++;
         if (wq[k].col !== 7 || wq[k].data !== k || wq[k].addr !== dst + k - 56) begin
            n_fail++;
            $display("FAIL full_col7 w%0d got col%0d @%0h=%0d expected col7 @%0h=%0d", k, wq[k].col, wq[k].addr, wq[k].data, dst + k - 56, k);
         end
      end
      n_checks++;
      if (wq[63].cyc - last_t0 !== 96) begin
         n_fail++;
         $display("FAIL full_duration got %0d expected 96", wq[63].cyc - last_t0);
      end
   endtask

   task automatic test_zero();
      run_tile("zero_rows", $urandom_range(0, 4095), $urandom_range(0, 255), 0, 4, 0);
      run_tile("zero_cols", $urandom_range(0, 4095), $urandom_range(0, 255), 5, 0, 0);
   endtask

   task automatic test_clamp_wrap();
      run_tile("clamp", $urandom_range(0, 4095), $urandom_range(0, 255), 3, 15, 0);
      run_tile("wrap", 'hFFF, 'hFE, 4, 2, 0);
      n_checks++;
      if (wq[0].addr !== 'hFE || wq[1].addr !== 'hFF || wq[2].addr !== 'h00 || wq[3].addr !== 'h01) begin
         n_fail++;
         $display("FAIL wrap_addr got %0h %0h %0h %0h expected fe ff 0 1", wq[0].addr, wq[1].addr, wq[2].addr, wq[3].addr);
      end
   endtask

   task automatic test_start_busy();
      run_tile("start_busy", $urandom_range(0, 4095), $urandom_range(0, 255), 3, 2, 5);
      run_tile("start_busy_long", $urandom_range(0, 4095), $urandom_range(0, 255), 7, 3, 12);
   endtask

   task automatic test_reset_mid();
      int nw;
      @(negedge clk);
      done_cnt = 0;
      wq.delete();
      bus.src_base = BAW'($urandom);
      bus.dst_base = AW'($urandom);
      bus.num_rows = 9'd8;
      bus.num_cols = 4'd8;
      bus.start    = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 200 && wq.size() < 10; i++) @(negedge clk);
      while (bus.bram_to_ram_w_en == '0) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid got en=%b wen=%h busy=%b done=%b expected all 0", bus.bram_en, bus.bram_to_ram_w_en, bus.busy, bus.done);
      end
      nw = wq.size();
      repeat (4) @(negedge clk);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++;
      if (done_cnt !== 0 || wq.size() !== nw) begin
         n_fail++;
         $display("FAIL reset_abort got %0d done pulses %0d extra writes expected 0 and 0", done_cnt, wq.size() - nw);
      end
      run_tile("after_reset", $urandom_range(0, 4095), $urandom_range(0, 255), 8, 8, 0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 5; t++)
         run_tile("random", $urandom_range(0, 4095), $urandom_range(0, 255), $urandom_range(1, 20), $urandom_range(1, 10), 0);
   endtask

   initial begin
      for (int i = 0; i < (1 << BAW); i++) mem[i] = $urandom;
      bus.start    = 1'b0;
      bus.src_base = '0;
      bus.dst_base = '0;
      bus.num_rows = '0;
      bus.num_cols = '0;
      test_reset();
      test_basic();
      test_full();
      test_zero();
      test_clamp_wrap();
      test_start_busy();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/w_buffer_loader.md
Name: w_buffer_loader

Overview:
- Upstream fill stage for the weight buffer. Streams a column-major weight tile out of a packed, wide on-chip BRAM and writes it into the ARRAY_M per-column weight RAMs, one WGT_WIDTH weight per cycle.
- Drives the weight buffer's write port (bram_to_ram_w_addr, one-hot bram_to_ram_w_en, bram_to_ram_w_data).
- Sequenced by the top-level controller with a start/busy/done handshake.

Parameters:
- ADDR_WIDTH, 8, weight-RAM address width; must match the weight buffer.
- ARRAY_M, 8, number of column RAMs in the weight buffer.
- WGT_WIDTH, 8, weight width in bits.
- BRAM_DATA_WIDTH, 32, source BRAM word width; must be an integer multiple of WGT_WIDTH.
- BRAM_ADDR_WIDTH, 12, source BRAM word-address width.
- BPW, BRAM_DATA_WIDTH/WGT_WIDTH, weights per BRAM word (derived).

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_base  in  BRAM_ADDR_WIDTH  BRAM word address of weight 0.
- dst_base  in  ADDR_WIDTH  weight-RAM address of row 0 in every column.
- num_rows  in  ADDR_WIDTH+1  rows per column (tile depth).
- num_cols  in  $clog2(ARRAY_M)+1  columns to fill; a value above ARRAY_M is treated as ARRAY_M.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  BRAM_ADDR_WIDTH  BRAM read address.
- bram_rdata  in  BRAM_DATA_WIDTH  BRAM read data; valid exactly 1 cycle after bram_en.
- bram_to_ram_w_addr  out  ADDR_WIDTH  weight-RAM write address.
- bram_to_ram_w_en  out  ARRAY_M  one-hot column write enable.
- bram_to_ram_w_data  out  WGT_WIDTH  write data.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, active-low): state IDLE; all outputs 0; all counters 0. Assertion mid-transfer aborts it immediately, with no further writes and no done pulse.
- Data layout:
  - Weight k (k = 0 .. num_cols*num_rows-1) sits in BRAM word src_base + k/BPW, little-endian lane k%BPW (lane 0 = bits [WGT_WIDTH-1:0]).
  - Weight k goes to column c = k/num_rows, address dst_base + (k%num_rows).
- start in IDLE latches src_base, dst_base, num_rows and clamped num_cols. start outside IDLE is ignored.
- If num_rows==0 or num_cols==0: IDLE -> DONE with no BRAM read and no write.
- Otherwise IDLE -> FETCH.
- FETCH (1 cycle): bram_en=1, bram_addr = word pointer. -> WAIT.
- WAIT (1 cycle): capture bram_rdata into the lane register. -> EMIT.
- EMIT (1 weight per cycle, up to BPW cycles):
  - bram_to_ram_w_en = 1<<col.
  - bram_to_ram_w_addr = dst_base + row, modulo 2^ADDR_WIDTH (wraps, no error).
  - bram_to_ram_w_data = current lane.
  - row increments per write. When row reaches num_rows-1, row returns to 0 and col increments in the same cycle. The column switch may fall mid-word.
  - After lane BPW-1 with weights remaining: word pointer +1 (wraps mod 2^BRAM_ADDR_WIDTH), -> FETCH.
  - After the final weight (partial word allowed): -> DONE. Unused lanes are never written.
- DONE (1 cycle): done=1, busy=0. -> IDLE. A start in this cycle is ignored.
- Timing:
  - Start sampled at edge 0: bram_en high in cycle 1; first write strobe in cycle 3.
  - Each full word takes 2+BPW cycles.
  - done is asserted the cycle after the last write strobe.
- Outputs are registered. w_en is all-zero outside EMIT. w_addr and w_data hold their last values when not writing.
- busy=1 in FETCH, WAIT and EMIT only.

Test Plan:
- Basic 2x3 tile: num_cols=2, num_rows=3, src_base=0x010, dst_base=0x20, BRAM[0x010]=0x44332211, BRAM[0x011]=0xXXXX6655.
  - Expected writes in order: col0 @0x20/21/22 = 11,22,33; col1 @0x20/21/22 = 44,55,66.
  - Exactly 2 BRAM reads; lanes 2-3 of word 0x011 never written.
  - done pulse 1 cycle after the 6th write; first write 3 cycles after start.
- Full 8x8 tile with byte pattern k:
  - 64 writes; column 7 receives 56..63 at dst_base..dst_base+7.
  - 16 BRAM reads; total 96 cycles start-to-last-write-inclusive.
- Zero-size tile: num_rows=0 (repeat with num_cols=0) -> done in cycle 2, no bram_en, no w_en.
- Clamp and wrap: num_cols=15 with ARRAY_M=8 -> only 8 columns written. dst_base=0xFE, num_rows=4 -> addresses 0xFE, 0xFF, 0x00, 0x01.
- Start while busy: second start in EMIT ignored; write sequence identical to the single-start run. A start on the done cycle is also ignored.
- Reset mid-EMIT: reset low asynchronously -> w_en, bram_en, busy, done all 0 immediately, no done pulse. A new start after release runs a clean full transfer.
